demux32_1x8_reg: RTL

//  Registered 1-to-8 distributor for 32-bit words, the inverse of the ALU's
//  3-bit-select 8:1 result mux. It routes one input word, selected by a 3-bit

---
 rtl/demux32_1x8_reg.sv | 95 +++++++++
 1 files changed

// File: rtl/demux32_1x8_reg.sv
// Registered 1-to-8 distributor: one DATA_W word is routed by a 3-bit select into one of eight single-entry
// output registers, each with its own valid/ready handshake. Optional broadcast port under DEMUX32_BROADCAST_EN.
module demux32_1x8_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
`ifdef DEMUX32_BROADCAST_EN
    input  logic                  bcast_i,
`endif
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    input  logic [2:0]            sel_3bit_i,
    output logic [7:0]            out_valid_o,
    input  logic [7:0]            out_ready_i,
    output logic [8*DATA_W-1:0]   out_data_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      xfer_cnt_o
);

    logic [7:0]        r_valid;
    logic [DATA_W-1:0] r_data [8];
    logic [CNT_W-1:0]  r_cnt;

    logic [7:0]        w_free;
    logic              w_bcast;
    logic              w_ready;
    logic              w_accept;
    logic [7:0]        w_load;

    // A channel can take a word if it is empty or is being drained on this same edge.
    assign w_free = ~r_valid | out_ready_i;

`ifdef DEMUX32_BROADCAST_EN
    assign w_bcast = in_valid_i & bcast_i;
`else
    assign w_bcast = 1'b0;
`endif

    always_comb begin
        w_ready = 1'b0;
        if (!rst_i) begin
            if (w_bcast) begin
                w_ready = &w_free;
            end else begin
                w_ready = w_free[sel_3bit_i];
            end
        end
    end

    assign w_accept = in_valid_i & w_ready;

    always_comb begin
        w_load = 8'h00;
        if (w_accept) begin
            if (w_bcast) begin
                w_load = 8'hFF;
            end else begin
                w_load[sel_3bit_i] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_chan
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
            end else if (w_load[k]) begin
                r_valid[k] <= 1'b1;
                r_data[k]  <= in_data_i;
            end else if (out_ready_i[k]) begin
                r_valid[k] <= 1'b0;
            end
        end

        assign out_data_o[k*DATA_W +: DATA_W] = r_data[k];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready_o  = w_ready;
    assign out_valid_o = r_valid;
    assign busy_o      = |r_valid;
    assign xfer_cnt_o  = r_cnt;

endmodule
